// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the stopwatch/countdown timer.
package stopwatch_pkg;

    // Controller state encoding; the numeric codes are visible on the mode output.
    typedef enum logic [2:0] {
        MODE_SELECT = 3'd0,
        SW_CLEAR    = 3'd1,
        SW_RUN      = 3'd2,
        SW_HOLD     = 3'd3,
        TM_INPUT    = 3'd4,
        TM_RUN      = 3'd5,
        TM_UP       = 3'd6
    } state_t;

    // mm:ss held as four BCD digits, most significant first.
    typedef struct packed {
        logic [3:0] m_tens;
        logic [3:0] m_units;
        logic [3:0] s_tens;
        logic [3:0] s_units;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = bcd_time_t'(16'h0000);
    localparam bcd_time_t TIME_MAX  = bcd_time_t'(16'h5959);
    localparam bcd_time_t TIME_ONE  = bcd_time_t'(16'h0001);

    // One-second increment with BCD carries; caller guards against TIME_MAX.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s_units != 4'd9) begin
            r.s_units = t.s_units + 4'd1;
        end else begin
            r.s_units = 4'd0;
            if (t.s_tens != 4'd5) begin
                r.s_tens = t.s_tens + 4'd1;
            end else begin
                r.s_tens = 4'd0;
                if (t.m_units != 4'd9) begin
                    r.m_units = t.m_units + 4'd1;
                end else begin
                    r.m_units = 4'd0;
                    r.m_tens  = t.m_tens + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // One-second decrement with BCD borrows; caller guards against TIME_ZERO.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s_units != 4'd0) begin
            r.s_units = t.s_units - 4'd1;
        end else begin
            r.s_units = 4'd9;
            if (t.s_tens != 4'd0) begin
                r.s_tens = t.s_tens - 4'd1;
            end else begin
                r.s_tens = 4'd5;
                if (t.m_units != 4'd0) begin
                    r.m_units = t.m_units - 4'd1;
                end else begin
                    r.m_units = 4'd9;
                    r.m_tens  = t.m_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_timer_ctrl_bcd_time_counter.sv
// Saturating BCD mm:ss up/down counter. Clear beats inc/dec; inc with dec is a no-op.
module bcd_time_counter
    import stopwatch_pkg::*;
(
    input  logic      clk,
    input  logic      nrst,
    input  logic      clear_i,
    input  logic      inc_i,
    input  logic      dec_i,
    output bcd_time_t time_o,
    output logic      is_zero_o,
    output logic      is_one_o
);

    bcd_time_t time_q;
    bcd_time_t time_d;

    // Next-time selection: clear, saturating increment, saturating decrement, or hold.
    always_comb begin
        time_d = time_q;
        if (clear_i) begin
            time_d = TIME_ZERO;
        end else if (inc_i && !dec_i) begin
            if (time_q != TIME_MAX) begin
                time_d = bcd_inc(time_q);
            end
        end else if (dec_i && !inc_i) begin
            if (time_q != TIME_ZERO) begin
                time_d = bcd_dec(time_q);
            end
        end
    end

    // Time register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            time_q <= TIME_ZERO;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_o    = time_q;
    assign is_zero_o = (time_q == TIME_ZERO);
    assign is_one_o  = (time_q == TIME_ONE);

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch / countdown-timer sequencer: mode FSM, button edge detect,
// one-second prescaler, driving the BCD mm:ss time counter.
module stopwatch_timer_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pb0,
    input  logic        pb1,
    input  logic        pb_inc,
    input  logic        pb_dec,
    output logic [15:0] disp_bcd,
    output logic [2:0]  mode,
    output logic        running,
    output logic        time_up
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;
    logic             pb0_q;
    logic             pb1_q;
    logic             pb_inc_q;
    logic             pb_dec_q;

    logic             ev_pb0;
    logic             ev_pb1;
    logic             ev_inc;
    logic             ev_dec;
    logic             in_run;
    logic             tick;

    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_dec;
    bcd_time_t        cnt_time;
    logic             cnt_is_zero;
    logic             cnt_is_one;

    // Rising-edge events; history resets high so a button held through reset is silent.
    assign ev_pb0 = pb0    & ~pb0_q;
    assign ev_pb1 = pb1    & ~pb1_q;
    assign ev_inc = pb_inc & ~pb_inc_q;
    assign ev_dec = pb_dec & ~pb_dec_q;

    assign in_run = (state_q == SW_RUN) || (state_q == TM_RUN);
    assign tick   = in_run && (presc_q == TICK_LAST);

    // Button history registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pb0_q    <= 1'b1;
            pb1_q    <= 1'b1;
            pb_inc_q <= 1'b1;
            pb_dec_q <= 1'b1;
        end else begin
            pb0_q    <= pb0;
            pb1_q    <= pb1;
            pb_inc_q <= pb_inc;
            pb_dec_q <= pb_dec;
        end
    end

    // Prescaler: held at zero outside the run states, so every run entry starts a full second.
    always_comb begin
        presc_d = '0;
        if (in_run && !tick) begin
            presc_d = presc_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Mode FSM and counter strobes; button priority is pb0, then pb1, then inc/dec.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            MODE_SELECT: begin
                if (ev_pb0) begin
                    state_d = SW_CLEAR;
                end else if (ev_pb1) begin
                    state_d   = TM_INPUT;
                    cnt_clear = 1'b1;
                end
            end
            SW_CLEAR: begin
                cnt_clear = 1'b1;
                state_d   = SW_RUN;
            end
            SW_RUN: begin
                // A tick coinciding with the stop press still counts.
                cnt_inc = tick;
                if (ev_pb0) begin
                    state_d = SW_HOLD;
                end
            end
            SW_HOLD: begin
                if (ev_pb0) begin
                    state_d = MODE_SELECT;
                end
            end
            TM_INPUT: begin
                if (ev_pb1) begin
                    if (!cnt_is_zero) begin
                        state_d = TM_RUN;
                    end
                end else begin
                    cnt_inc = ev_inc;
                    cnt_dec = ev_dec;
                end
            end
            TM_RUN: begin
                cnt_dec = tick;
                if (ev_pb0) begin
                    state_d = MODE_SELECT;
                end else if (tick && cnt_is_one) begin
                    state_d = TM_UP;
                end
            end
            TM_UP: begin
                if (ev_pb0) begin
                    state_d = MODE_SELECT;
                end
            end
            default: begin
                state_d = MODE_SELECT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= MODE_SELECT;
        end else begin
            state_q <= state_d;
        end
    end

    bcd_time_counter u_cnt (
        .clk       (clk),
        .nrst      (nrst),
        .clear_i   (cnt_clear),
        .inc_i     (cnt_inc),
        .dec_i     (cnt_dec),
        .time_o    (cnt_time),
        .is_zero_o (cnt_is_zero),
        .is_one_o  (cnt_is_one)
    );

    assign disp_bcd = cnt_time;
    assign mode     = state_q;
    assign running  = in_run;
    assign time_up  = (state_q == TM_UP);

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed bench for stopwatch_timer_ctrl with a 4-cycle second.
module tb_stopwatch_timer_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        pb0;
    logic        pb1;
    logic        pb_inc;
    logic        pb_dec;
    logic [15:0] disp_bcd;
    logic [2:0]  mode;
    logic        running;
    logic        time_up;

    int checks = 0;
    int fails  = 0;

    stopwatch_timer_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .pb0      (pb0),
        .pb1      (pb1),
        .pb_inc   (pb_inc),
        .pb_dec   (pb_dec),
        .disp_bcd (disp_bcd),
        .mode     (mode),
        .running  (running),
        .time_up  (time_up)
    );

    always #5 clk = ~clk;

    // One-cycle press followed by one idle cycle; starts and ends on a falling edge.
    task automatic pulse(input int sel);
        case (sel)
            0: pb0 = 1'b1;
            1: pb1 = 1'b1;
            2: pb_inc = 1'b1;
            default: pb_dec = 1'b1;
        endcase
        @(negedge clk);
        pb0 = 1'b0; pb1 = 1'b0; pb_inc = 1'b0; pb_dec = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b0; pb0 = 1'b1; pb1 = 1'b0; pb_inc = 1'b0; pb_dec = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL rst_mode: got %0d want 0", mode); end
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL rst_disp: got %h want 0000", disp_bcd); end
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL held_pb0_mode: got %0d want 0", mode); end
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL held_pb0_running: got %b want 0", running); end
        checks++; if (time_up !== 1'b0) begin fails++; $display("FAIL rst_time_up: got %b want 0", time_up); end
        pb0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stopwatch;
        // Run entry at edge E1; ticks land on E5, E9, ... ; stop press lands on E37 (9th tick).
        pulse(0);
        repeat (35) @(negedge clk);
        checks++; if (mode !== 3'd2) begin fails++; $display("FAIL sw_run_mode: got %0d want 2", mode); end
        checks++; if (running !== 1'b1) begin fails++; $display("FAIL sw_running: got %b want 1", running); end
        checks++; if (disp_bcd !== 16'h0008) begin fails++; $display("FAIL sw_run_disp: got %h want 0008", disp_bcd); end
        pulse(0);
        checks++; if (mode !== 3'd3) begin fails++; $display("FAIL sw_hold_mode: got %0d want 3", mode); end
        checks++; if (disp_bcd !== 16'h0009) begin fails++; $display("FAIL sw_hold_disp: got %h want 0009", disp_bcd); end
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL sw_hold_running: got %b want 0", running); end
        repeat (8) @(negedge clk);
        checks++; if (disp_bcd !== 16'h0009) begin fails++; $display("FAIL sw_hold_frozen: got %h want 0009", disp_bcd); end
        pulse(0);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL sw_back_mode: got %0d want 0", mode); end
        checks++; if (disp_bcd !== 16'h0009) begin fails++; $display("FAIL sw_back_disp: got %h want 0009", disp_bcd); end
    endtask

    task automatic test_timer;
        pulse(1);
        checks++; if (mode !== 3'd4) begin fails++; $display("FAIL tm_input_mode: got %0d want 4", mode); end
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL tm_input_clear: got %h want 0000", disp_bcd); end
        pulse(2); pulse(2); pulse(2); pulse(3);
        checks++; if (disp_bcd !== 16'h0002) begin fails++; $display("FAIL tm_entry: got %h want 0002", disp_bcd); end
        // Run entry at edge Ea; ticks at Ea+4 and Ea+8.
        pulse(1);
        checks++; if (mode !== 3'd5) begin fails++; $display("FAIL tm_run_mode: got %0d want 5", mode); end
        checks++; if (running !== 1'b1) begin fails++; $display("FAIL tm_running: got %b want 1", running); end
        repeat (6) @(negedge clk);
        checks++; if (disp_bcd !== 16'h0001) begin fails++; $display("FAIL tm_one: got %h want 0001", disp_bcd); end
        checks++; if (time_up !== 1'b0) begin fails++; $display("FAIL tm_early_up: got %b want 0", time_up); end
        @(negedge clk);
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL tm_zero: got %h want 0000", disp_bcd); end
        checks++; if (mode !== 3'd6) begin fails++; $display("FAIL tm_up_mode: got %0d want 6", mode); end
        checks++; if (time_up !== 1'b1) begin fails++; $display("FAIL tm_up_flag: got %b want 1", time_up); end
        repeat (8) @(negedge clk);
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL tm_up_hold: got %h want 0000", disp_bcd); end
        pulse(0);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL tm_ack_mode: got %0d want 0", mode); end
        checks++; if (time_up !== 1'b0) begin fails++; $display("FAIL tm_ack_flag: got %b want 0", time_up); end
    endtask

    task automatic test_entry;
        pulse(1);
        pulse(3);
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL dec_sat: got %h want 0000", disp_bcd); end
        pulse(1);
        checks++; if (mode !== 3'd4) begin fails++; $display("FAIL zero_start_ignored: got %0d want 4", mode); end
        for (int i = 0; i < 59; i++) pulse(2);
        checks++; if (disp_bcd !== 16'h0059) begin fails++; $display("FAIL preload_59: got %h want 0059", disp_bcd); end
        pulse(2);
        checks++; if (disp_bcd !== 16'h0100) begin fails++; $display("FAIL carry_100: got %h want 0100", disp_bcd); end
        pb_inc = 1'b1; pb_dec = 1'b1;
        @(negedge clk);
        pb_inc = 1'b0; pb_dec = 1'b0;
        @(negedge clk);
        checks++; if (disp_bcd !== 16'h0100) begin fails++; $display("FAIL inc_dec_noop: got %h want 0100", disp_bcd); end
        pulse(3);
        checks++; if (disp_bcd !== 16'h0059) begin fails++; $display("FAIL borrow_059: got %h want 0059", disp_bcd); end
        // Stop press two edges after run entry, before the first tick.
        pulse(1);
        checks++; if (mode !== 3'd5) begin fails++; $display("FAIL entry_run_mode: got %0d want 5", mode); end
        pulse(0);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL tm_abort_mode: got %0d want 0", mode); end
        checks++; if (disp_bcd !== 16'h0059) begin fails++; $display("FAIL tm_abort_frozen: got %h want 0059", disp_bcd); end
    endtask

    task automatic test_back_to_back;
        pb0 = 1'b1; pb1 = 1'b1;
        @(negedge clk);
        pb0 = 1'b0; pb1 = 1'b0;
        checks++; if (mode !== 3'd1) begin fails++; $display("FAIL prio_pb0: got %0d want 1", mode); end
        @(negedge clk);
        checks++; if (mode !== 3'd2) begin fails++; $display("FAIL clear_to_run: got %0d want 2", mode); end
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL sw_cleared: got %h want 0000", disp_bcd); end
        // Run entered on the edge just passed; 3598 ticks give 59:58.
        repeat (14392) @(negedge clk);
        checks++; if (disp_bcd !== 16'h5958) begin fails++; $display("FAIL sw_5958: got %h want 5958", disp_bcd); end
        repeat (4) @(negedge clk);
        checks++; if (disp_bcd !== 16'h5959) begin fails++; $display("FAIL sw_5959: got %h want 5959", disp_bcd); end
        repeat (12) @(negedge clk);
        checks++; if (disp_bcd !== 16'h5959) begin fails++; $display("FAIL sw_saturate: got %h want 5959", disp_bcd); end
        pulse(0);
        pulse(0);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL sat_back_mode: got %0d want 0", mode); end
    endtask

    task automatic test_async_reset;
        pulse(1);
        for (int i = 0; i < 5; i++) pulse(2);
        pulse(1);
        checks++; if (disp_bcd !== 16'h0005) begin fails++; $display("FAIL ar_pre_disp: got %h want 0005", disp_bcd); end
        checks++; if (mode !== 3'd5) begin fails++; $display("FAIL ar_pre_mode: got %0d want 5", mode); end
        #2 nrst = 1'b0;
        #1;
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL ar_mode: got %0d want 0", mode); end
        checks++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL ar_disp: got %h want 0000", disp_bcd); end
        checks++; if (running !== 1'b0) begin fails++; $display("FAIL ar_running: got %b want 0", running); end
        checks++; if (time_up !== 1'b0) begin fails++; $display("FAIL ar_time_up: got %b want 0", time_up); end
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mode !== 3'd0) begin fails++; $display("FAIL ar_after_mode: got %0d want 0", mode); end
    endtask

    initial begin
        test_reset();
        test_stopwatch();
        test_timer();
        test_entry();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer_ctrl.md
Name: stopwatch_timer_ctrl

Overview:
Sequencer for the stopwatch/countdown-timer feature. It owns the mode state machine, the button edge detection, the one-second prescaler and the BCD mm:ss time register. It drives the 4-digit display value plus status flags to the display/LED logic. It replaces ad-hoc control strobes with one self-contained controller.

Parameters:
TICK_DIV, 10_000_000, clk cycles per one-second tick (benches override to 4)
CNT_W, 24, prescaler width; must satisfy 2**CNT_W >= TICK_DIV

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
pb0  in  1  debounced level: start/stop/acknowledge
pb1  in  1  debounced level: mode select/enter
pb_inc  in  1  debounced level: timer entry +1 s
pb_dec  in  1  debounced level: timer entry -1 s
disp_bcd  out  16  {m_tens, m_units, s_tens, s_units}, BCD
mode  out  3  current state encoding
running  out  1  high in SW_RUN and TM_RUN
time_up  out  1  high in TM_UP

Behaviour:
- One clock domain; reset is asynchronous and active-low (clk, nrst). All state is registered.
- Reset values: state=MODE_SELECT, time=00:00, prescaler=0, button-history regs=1, running=0, time_up=0, disp_bcd=16'h0000, mode=MODE_SELECT code.
- Edge detect: ev_x = pb_x & ~pb_x_q, a one-cycle event. History regs reset to 1, so a button held through reset produces no event.
- Prescaler:
  - Counts only in SW_RUN/TM_RUN.
  - tick=1 when prescaler==TICK_DIV-1, then wraps to 0.
  - Forced to 0 on entry to SW_RUN and TM_RUN.
  - First tick occurs TICK_DIV cycles after entry.
- Time register, BCD digits:
  - Up-count carries s_units 9->0, s_tens 5->0, m_units 9->0, m_tens.
  - Saturates at 59:59.
  - Down-count borrows symmetrically and saturates at 00:00.
- States and transitions (event priority pb0 > pb1 > inc/dec):
  - MODE_SELECT: ev_pb0 -> SW_CLEAR. ev_pb1 -> TM_INPUT and time:=00:00. Otherwise hold. Display shows the retained time.
  - SW_CLEAR: time:=00:00, then unconditionally SW_RUN next cycle.
  - SW_RUN: tick -> time+1. ev_pb0 -> SW_HOLD. If tick and ev_pb0 coincide, the increment is kept.
  - SW_HOLD: time frozen. ev_pb0 -> MODE_SELECT.
  - TM_INPUT: ev_inc -> time+1 (saturating). ev_dec -> time-1 (saturating). inc and dec in the same cycle -> no change. ev_pb1 with time!=00:00 -> TM_RUN. ev_pb1 with time==00:00 is ignored.
  - TM_RUN: tick -> time-1. A tick at 00:01 writes 00:00 and enters TM_UP on the same edge. ev_pb0 -> MODE_SELECT with time frozen. If ev_pb0 and a terminal tick coincide, go to MODE_SELECT.
  - TM_UP: time_up=1, time stays 00:00. ev_pb0 -> MODE_SELECT.
- Outputs:
  - running, time_up and mode are decoded from registered state, so they are valid the cycle the state is entered.
  - disp_bcd is a direct wire from the time register.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. No pending event survives.
- Unused enum encodings recover to MODE_SELECT next cycle.

Decomposition:
- Package stopwatch_pkg:
  - state_t enum, 3 bits: MODE_SELECT=0, SW_CLEAR=1, SW_RUN=2, SW_HOLD=3, TM_INPUT=4, TM_RUN=5, TM_UP=6.
  - bcd_time_t packed struct of four 4-bit digits.
  - constants TIME_ZERO and TIME_MAX.
- Sub-module bcd_time_counter:
  - Inputs: clear, inc, dec (one-cycle).
  - Outputs: time, is_zero, is_one.
  - Saturating BCD up/down; clear wins over inc/dec; inc and dec together is a no-op.
- The controller holds the FSM, the edge detectors and the prescaler.

Test Plan:
- Reset with pb0 held high, then release -> no event; state MODE_SELECT; disp 0000; running=0.
- TICK_DIV=4: pulse pb0 (MODE_SELECT), wait 40 cycles, pulse pb0 -> state SW_HOLD, disp 0009 (SW_CLEAR 1 cycle, then ticks every 4); a further pb0 -> MODE_SELECT, disp still 0009.
- pb1; pb_inc x3; pb_dec x1; pb1 -> TM_RUN from 0002. After 8 cycles -> 0000, TM_UP, time_up=1 on the same edge as the 0000 load. pb0 -> MODE_SELECT, time_up=0.
- In TM_INPUT at 0000: pb_dec then pb1 -> stays 0000, state TM_INPUT. Preload 0059 (x59 inc) + 1 inc -> 0100 carry check.
- Stopwatch preloaded to 59:58 (force via hierarchy): 3 ticks -> 5959 and holds.
- Assert nrst low mid-TM_RUN at 0005 -> state MODE_SELECT, disp 0000, time_up=0 asynchronously, before the next clk edge.
